// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the sequential Y86-64 datapath: owns the PC, steps
// one stage per cycle, waits on the data-memory handshake and tracks status.
module y86_seq_controller #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_pc,
  input  logic [63:0]      start_pc,
  input  logic             pause,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             instr_valid,
  input  logic             cnd,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [63:0]      valM,
  input  logic             mem_ack,
  input  logic             dmem_error,
  output logic [63:0]      PC,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pcupd_en,
  output logic             mem_req,
  output logic [2:0]       stat,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state_q;
  logic [63:0]        pc_q;
  logic [2:0]         stat_q;
  logic [CNT_W-1:0]   count_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               needs_mem;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  always_comb begin
    needs_mem = 1'b0;
    case (icode)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: needs_mem = 1'b1;
      default:                            needs_mem = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (load_pc) pc_q <= start_pc;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_error) begin
            stat_q  <= STAT_ADR;
            state_q <= S_HALT;
          end else if (!instr_valid) begin
            stat_q  <= STAT_INS;
            state_q <= S_HALT;
          end else if (icode == 4'h0) begin
            stat_q  <= STAT_HLT;
            state_q <= S_HALT;
          end else begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= S_EXECUTE;
        S_EXECUTE: begin
          wait_q  <= '0;
          state_q <= needs_mem ? S_MEMORY : S_WRITEBACK;
        end
        S_MEMORY: begin
          // an ack on the final allowed cycle still wins over the timeout
          if (mem_ack) begin
            if (dmem_error) begin
              stat_q  <= STAT_ADR;
              state_q <= S_HALT;
            end else begin
              state_q <= S_WRITEBACK;
            end
          end else if (wait_q == WAIT_LAST) begin
            stat_q  <= STAT_ADR;
            state_q <= S_HALT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WRITEBACK: state_q <= S_PCUPD;
        S_PCUPD: begin
          if (icode == 4'h8 || (icode == 4'h7 && cnd)) pc_q <= valC;
          else if (icode == 4'h9)                      pc_q <= valM;
          else                                         pc_q <= valP;
          count_q <= count_q + CNT_W'(1);
          state_q <= pause ? S_IDLE : S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fetch_en     = (state_q == S_FETCH);
  assign decode_en    = (state_q == S_DECODE);
  assign execute_en   = (state_q == S_EXECUTE);
  assign memory_en    = (state_q == S_MEMORY);
  assign writeback_en = (state_q == S_WRITEBACK);
  assign pcupd_en     = (state_q == S_PCUPD);
  assign mem_req      = (state_q == S_MEMORY);
  assign running      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted       = (state_q == S_HALT);
  assign PC           = pc_q;
  assign stat         = stat_q;
  assign instr_count  = count_q;
  assign state_dbg    = state_q;

endmodule
